// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and widths for the UART frame sequencer
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int UART_IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_FIN
    } uart_state_e;

endpackage

// File: rtl/uart_frame_sender.sv
// rtl/uart_frame_sender.sv - splits a multi-byte word into LSB-first bytes for the UART transmitter
// Optional trailing XOR checksum byte: UART_FRAME_CKSUM_EN
module uart_frame_sender
    import uart_pkg::*;
#(
    parameter int N_BYTES = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [UART_BYTE_W*N_BYTES-1:0] data_in,
    input  logic                           tx_done,
    output logic                           send_en,
    output logic [UART_BYTE_W-1:0]         data_byte,
    output logic                           busy,
    output logic                           done
);

    localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(N_BYTES - 1);

    uart_state_e                       state_q;
    logic [UART_IDX_W-1:0]             idx_q;
    logic [UART_BYTE_W*N_BYTES-1:0]    shadow_q;
    logic                              send_en_q;
    logic [UART_BYTE_W-1:0]            data_byte_q;
    logic                              busy_q;
    logic                              done_q;
    logic [UART_BYTE_W-1:0]            payload_byte;
    logic [UART_BYTE_W-1:0]            cur_byte;

    always_comb begin
        payload_byte = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            if (idx_q == UART_IDX_W'(i)) begin
                payload_byte = shadow_q[i*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

`ifdef UART_FRAME_CKSUM_EN
    logic [UART_BYTE_W-1:0] cksum_d;
    logic [UART_BYTE_W-1:0] cksum_q;
    logic                   ck_phase_q;

    always_comb begin
        cksum_d = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            cksum_d = cksum_d ^ data_in[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    assign cur_byte = ck_phase_q ? cksum_q : payload_byte;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cksum_q    <= '0;
            ck_phase_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            cksum_q    <= cksum_d;
            ck_phase_q <= 1'b0;
        end else if (state_q == ST_WAIT && tx_done && idx_q == LAST_IDX) begin
            ck_phase_q <= 1'b1;
        end
    end
`else
    assign cur_byte = payload_byte;
`endif

    // SEND entered from WAIT spends one cycle loading the byte, so the next
    // send_en lands two edges after the accepted tx_done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            send_en_q   <= 1'b0;
            data_byte_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shadow_q    <= data_in;
                        idx_q       <= '0;
                        send_en_q   <= 1'b1;
                        data_byte_q <= data_in[UART_BYTE_W-1:0];
                        busy_q      <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (send_en_q) begin
                        send_en_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end else begin
                        send_en_q   <= 1'b1;
                        data_byte_q <= cur_byte;
                    end
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (idx_q != LAST_IDX) begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_SEND;
`ifdef UART_FRAME_CKSUM_EN
                        end else if (!ck_phase_q) begin
                            state_q <= ST_SEND;
`endif
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign send_en   = send_en_q;
    assign data_byte = data_byte_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// tb/tb_uart_frame_sender.sv - directed bench for uart_frame_sender (N_BYTES=4 and N_BYTES=1)
module tb_uart_frame_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        start4, tx_done4, send_en4, busy4, done4;
    logic [31:0] data4;
    logic [7:0]  byte4;
    logic        start1, tx_done1, send_en1, busy1, done1;
    logic [7:0]  data1;
    logic [7:0]  byte1;

    uart_frame_sender #(.N_BYTES(4)) dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .data_in(data4), .tx_done(tx_done4),
        .send_en(send_en4), .data_byte(byte4), .busy(busy4), .done(done4)
    );

    uart_frame_sender #(.N_BYTES(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .data_in(data1), .tx_done(tx_done1),
        .send_en(send_en1), .data_byte(byte1), .busy(busy1), .done(done1)
    );

`ifdef UART_FRAME_CKSUM_EN
    localparam int N1_SENDS = 2;
`else
    localparam int N1_SENDS = 1;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transmitter models plus monitors, all evaluated on the falling edge
    logic [7:0] got4[$];
    logic [7:0] exp_q[$];
    int sends4 = 0, dones4 = 0, txcyc4 = 0, donegap4 = 0, sendgap4 = 0, busyerr4 = 0;
    int cnt4 = 0, tx_delay4 = 20;
    bit in_frame4 = 0, after_tx4 = 0, inject4 = 0;
    int sends1 = 0, dones1 = 0, txcyc1 = 0, donegap1 = 0, cnt1 = 0;

    initial begin tx_done4 = 1'b0; tx_done1 = 1'b0; end

    always @(negedge clk) begin
        if (!rstn) begin
            in_frame4 = 0;
            after_tx4 = 0;
        end else begin
            if (in_frame4 && !busy4) busyerr4++;
            if (send_en4) begin
                got4.push_back(byte4);
                sends4++;
                in_frame4 = 1;
                if (after_tx4) sendgap4 = cyc - txcyc4;
                after_tx4 = 0;
            end
            if (done4) begin
                dones4++;
                donegap4 = cyc - txcyc4;
                in_frame4 = 0;
                after_tx4 = 0;
            end
        end
        tx_done4 = 1'b0;
        if (cnt4 > 0) begin
            cnt4--;
            if (cnt4 == 0) tx_done4 = 1'b1;
        end
        if (inject4) tx_done4 = 1'b1;
        if (tx_done4) begin
            txcyc4 = cyc;
            if (in_frame4) after_tx4 = 1;
        end
        if (send_en4) cnt4 = tx_delay4;
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (send_en1) sends1++;
            if (done1) begin dones1++; donegap1 = cyc - txcyc1; end
        end
        tx_done1 = 1'b0;
        if (cnt1 > 0) begin
            cnt1--;
            if (cnt1 == 0) begin tx_done1 = 1'b1; txcyc1 = cyc; end
        end
        if (send_en1) cnt1 = 20;
    end

    task automatic pulse_start4(input logic [31:0] d);
        @(posedge clk); #1;
        data4  = d;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic wait_done4(input string tag);
        int d0 = dones4;
        int n  = 0;
        while (dones4 == d0 && n < 500) begin @(negedge clk); #1; n++; end
        check({tag, "_done_seen"}, dones4 - d0, 1);
    endtask

    task automatic wait_done1(input string tag);
        int d0 = dones1;
        int n  = 0;
        while (dones1 == d0 && n < 500) begin @(negedge clk); #1; n++; end
        check({tag, "_done_seen"}, dones1 - d0, 1);
    endtask

    task automatic wait_bytes4(input int cnt, input string tag);
        int n = 0;
        while (got4.size() < cnt && n < 200) begin @(negedge clk); #1; n++; end
        check({tag, "_byte_count_reached"}, got4.size(), cnt);
    endtask

    task automatic check_bytes4(input string tag);
        check({tag, "_nbytes"}, got4.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), (i < got4.size()) ? {24'h0, got4[i]} : 32'hFFFF_FFFF,
                  {24'h0, exp_q[i]});
        end
    endtask

    initial begin
        int s0;
        rstn = 1'b0; start4 = 1'b0; data4 = '0; start1 = 1'b0; data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_send_en", send_en4, 0);
        check("rst_data_byte", byte4, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        rstn = 1'b1;

        // Basic frame
        got4.delete();
        exp_q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
`ifdef UART_FRAME_CKSUM_EN
        exp_q.push_back(8'h04);
`endif
        busyerr4 = 0;
        pulse_start4(32'hA1B2C3D4);
        check("t1_first_send_en", send_en4, 1);
        check("t1_first_busy", busy4, 1);
        check("t1_first_byte", byte4, 8'hD4);
        wait_done4("t1");
        check_bytes4("t1");
        check("t1_done_gap", donegap4, 1);
        check("t1_send_gap", sendgap4, 2);
        check("t1_busy_held", busyerr4, 0);
        @(negedge clk); #1;
        check("t1_busy_fall", busy4, 0);

        // start while byte 1 is in flight is ignored
        got4.delete();
        pulse_start4(32'hA1B2C3D4);
        wait_bytes4(2, "t2");
        pulse_start4(32'h11223344);
        check("t2_byte_hold", byte4, 8'hC3);
        wait_done4("t2");
        check_bytes4("t2");

        // Spurious tx_done in IDLE
        s0 = sends4;
        @(posedge clk); #1; inject4 = 1;
        @(posedge clk); #1; inject4 = 0;
        repeat (5) @(negedge clk);
        #1;
        check("t3_spurious_sends", sends4 - s0, 0);
        check("t3_spurious_busy", busy4, 0);

        // tx_done in the cycle right after send_en
        tx_delay4 = 1;
        got4.delete();
        exp_q = '{8'h3C, 8'h2D, 8'h1E, 8'h0F};
`ifdef UART_FRAME_CKSUM_EN
        exp_q.push_back(8'h00);
`endif
        pulse_start4(32'h0F1E2D3C);
        wait_done4("t3b");
        check_bytes4("t3b");
        check("t3b_send_gap", sendgap4, 2);
        check("t3b_done_gap", donegap4, 1);
        tx_delay4 = 20;
        repeat (3) @(posedge clk);

        // Reset during WAIT of byte 2
        got4.delete();
        pulse_start4(32'hA1B2C3D4);
        wait_bytes4(3, "t4");
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("t4_rst_send_en", send_en4, 0);
        check("t4_rst_data_byte", byte4, 0);
        check("t4_rst_busy", busy4, 0);
        check("t4_rst_done", done4, 0);
        @(posedge clk); #1 rstn = 1'b1;
        s0 = sends4;
        repeat (30) @(posedge clk);
        #1;
        check("t4_late_txdone_sends", sends4 - s0, 0);
        check("t4_late_txdone_busy", busy4, 0);
        got4.delete();
        exp_q = '{8'h88, 8'h77, 8'h66, 8'h55};
`ifdef UART_FRAME_CKSUM_EN
        exp_q.push_back(8'hCC);
`endif
        pulse_start4(32'h55667788);
        check("t4_new_send_en", send_en4, 1);
        check("t4_new_byte0", byte4, 8'h88);
        wait_done4("t4");
        check_bytes4("t4");

        // Single-byte frames, back to back
        s0 = sends1;
        @(posedge clk); #1; data1 = 8'h5A; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        check("t5_send_en", send_en1, 1);
        check("t5_byte", byte1, 8'h5A);
        wait_done1("t5");
        check("t5_sends", sends1 - s0, N1_SENDS);
        check("t5_done_gap", donegap1, 1);
        @(posedge clk); #1;
        check("t5_idle_busy", busy1, 0);
        data1 = 8'hC3; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        check("t5_b2b_send_en", send_en1, 1);
        check("t5_b2b_byte", byte1, 8'hC3);
        check("t5_b2b_busy", busy1, 1);
        wait_done1("t5_b2b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_sender.md
# uart_frame_sender

Upstream sequencer for the single-byte UART transmitter. Accepts a multi-byte word on a one-cycle start strobe and splits it into bytes, least-significant byte first. Hands each byte to the transmitter with a one-cycle `send_en` pulse, then waits for that byte's `tx_done` before issuing the next one. Sits between the system-side producer and the UART transmitter, and reports frame-level `busy` and `done`.

## Interface
- `N_BYTES`, default 4: number of payload bytes per frame, range 1–16.
- `clk`  in  1: system clock.
- `rstn`  in  1: reset; asynchronous, active-low.
- `start`  in  1: one-cycle request to send a frame.
- `data_in`  in  8*N_BYTES: frame payload. Byte i is `data_in[8i+7:8i]`.
- `tx_done`  in  1: one-cycle pulse from the transmitter when the current byte has finished.
- `send_en`  out  1: one-cycle pulse to the transmitter to start a byte.
- `data_byte`  out  8: byte presented to the transmitter.
- `busy`  out  1: high from frame acceptance until `done`.
- `done`  out  1: one-cycle pulse when the last byte's `tx_done` has been received.

## Operation
- The FSM has four states: IDLE, SEND, WAIT and FIN. A 4-bit byte index `idx` counts bytes within the frame.
- IDLE:
  - `start` = 1 latches `data_in` into a shadow register, clears `idx` and moves to SEND.
  - `start` is ignored in every state other than IDLE. No queueing.
- SEND:
  - `send_en` = 1 for exactly one cycle.
  - `data_byte` = shadow byte `idx`.
  - Moves to WAIT.
- WAIT (waiting for `tx_done`):
  - If `idx` is not the last byte: increment `idx` and return to SEND.
  - If `idx` == last: move to FIN.
- FIN: `done` = 1 for one cycle, then return to IDLE.
- `tx_done` arriving in IDLE, SEND or FIN is ignored.
- `data_byte` is registered. It holds its value from the SEND cycle until the next SEND cycle, so the transmitter may sample it at any time while it is busy.
- Wrap-around: `idx` never exceeds the last byte index; it is cleared on every frame accept.
- Reset, including in the middle of a frame:
  - All outputs go to 0: `send_en`, `data_byte`, `busy`, `done`.
  - FSM goes to IDLE, `idx` = 0, shadow register = 0.
  - The frame in progress is dropped. A `tx_done` from the transmitter after reset is ignored.

## Timing
- `start` sampled at edge k: `busy` and `send_en` are high in cycle k+1. Byte 0 goes out on `data_byte` in the same cycle.
- `tx_done` sampled at edge m while in WAIT:
  - Not the last byte: the next `send_en` is high in cycle m+2, because the FSM passes through WAIT→SEND.
  - Last byte: `done` is high in cycle m+1.
- `busy` falls in the cycle after `done`. A new `start` is accepted at the first edge where the FSM is in IDLE, so frames can run back-to-back with one idle cycle between them.
- Latency from `start` to the first `send_en` is 1 cycle. After that, the frame time is set entirely by the transmitter.

## Configuration
- `UART_FRAME_CKSUM_EN` defined:
  - After the payload, one extra byte is sent: the XOR of all payload bytes.
  - The total is N_BYTES+1 `send_en` pulses.
  - The checksum is accumulated as the shadow register is loaded, so it is ready when the last payload byte completes.
  - `done` follows the `tx_done` of the checksum byte.
- Not defined: exactly N_BYTES bytes are sent, and no checksum logic is generated.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, SEND, WAIT, FIN);
  - the `UART_BYTE_W` = 8 constant;
  - the `UART_IDX_W` = 4 constant.
- No sub-module. The byte mux and the XOR accumulator are small enough to stay inline.
- The transmitter is instantiated alongside this block at the next level up, not inside it.

## Test plan
- Bench setup: a transmitter model that pulses `tx_done` 20 cycles after each `send_en`.
- N_BYTES=4, `data_in`=32'hA1B2C3D4, `start` pulse:
  - `data_byte` sequence is D4, C3, B2, A1, with 4 `send_en` pulses;
  - `done` comes 1 cycle after the 4th `tx_done`;
  - `busy` stays high throughout.
- Same frame with `UART_FRAME_CKSUM_EN` defined: 5 bytes D4, C3, B2, A1, 04; `done` follows the 5th `tx_done`.
- `start` re-asserted with `data_in`=32'h11223344 while byte 1 is in flight: ignored, and the output sequence is unchanged.
- Spurious `tx_done` in IDLE: no `send_en`, `busy` stays 0. `tx_done` in the cycle right after `send_en`: accepted, and the next byte follows at m+2.
- `rstn` low during WAIT of byte 2: all outputs go to 0 immediately. The next `tx_done` is ignored. A new `start` sends byte 0 of the new frame.
- N_BYTES=1, `data_in`=8'h5A: one `send_en` with 5A; `done` 1 cycle after `tx_done`. Back-to-back `start` on the first IDLE cycle is accepted.
